// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit alongside the EX-stage ALU: MULT/MULTU, MTHI/MTLO, MFHI/MFLO.
// Define MULDIV_DIV_EN to build DIV/DIVU support; without it, sel 26/27 are ignored.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sout,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] SEL_MFHI  = 6'd16;
  localparam logic [5:0] SEL_MTHI  = 6'd17;
  localparam logic [5:0] SEL_MFLO  = 6'd18;
  localparam logic [5:0] SEL_MTLO  = 6'd19;
  localparam logic [5:0] SEL_MULT  = 6'd24;
  localparam logic [5:0] SEL_MULTU = 6'd25;
`ifdef MULDIV_DIV_EN
  localparam logic [5:0] SEL_DIV   = 6'd26;
  localparam logic [5:0] SEL_DIVU  = 6'd27;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX} state_t;
`endif

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opb;
  logic        sa, sb;
  logic        is_mul, is_div, is_hilo, op_signed, accept;
  logic [31:0] abs_a, abs_b;
  logic [32:0] msum;
  logic [63:0] acc_mul;
  logic [63:0] mprod;
  logic [31:0] fix_hi, fix_lo;

  assign is_mul  = (sel == SEL_MULT) | (sel == SEL_MULTU);
`ifdef MULDIV_DIV_EN
  assign is_div  = (sel == SEL_DIV) | (sel == SEL_DIVU);
`else
  assign is_div  = 1'b0;
`endif
  assign is_hilo   = (sel[5:2] == 4'b0100);
  assign op_signed = ~sel[0];
  assign busy      = (state != S_IDLE);
  assign accept    = start & ~busy & (is_mul | is_div);
  assign stall     = busy & start & (is_hilo | is_mul | is_div);

  assign abs_a = (op_signed && a[31]) ? -a : a;
  assign abs_b = (op_signed && b[31]) ? -b : b;

  always_comb begin
    sout = '0;
    if (!busy) begin
      if (sel == SEL_MFHI)      sout = hi;
      else if (sel == SEL_MFLO) sout = lo;
    end
  end

  // Shift-add step: acc holds {partial sum, remaining multiplier bits}.
  assign msum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
  assign acc_mul = {msum, acc[31:1]};
  assign mprod   = (sa ^ sb) ? -acc : acc;

`ifdef MULDIV_DIV_EN
  logic        op_div, dz;
  logic [32:0] dtrial;
  logic [63:0] acc_div;

  // Restoring step: acc holds {remainder, dividend/quotient}; borrow in bit 32 means restore.
  assign dtrial  = acc[63:31] - {1'b0, opb};
  assign acc_div = dtrial[32] ? {acc[62:0], 1'b0} : {dtrial[31:0], acc[30:0], 1'b1};
`endif

  always_comb begin
    fix_hi = mprod[63:32];
    fix_lo = mprod[31:0];
`ifdef MULDIV_DIV_EN
    if (op_div) begin
      fix_hi = sa ? -acc[63:32] : acc[63:32];
      fix_lo = dz ? '1 : ((sa ^ sb) ? -acc[31:0] : acc[31:0]);
    end
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_MUL;
`ifdef MULDIV_DIV_EN
          if (is_div) state_nx = S_DIV;
`endif
        end
      end
      S_MUL: if (cnt == '0) state_nx = S_FIX;
`ifdef MULDIV_DIV_EN
      S_DIV: if (cnt == '0) state_nx = S_FIX;
`endif
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      opb  <= '0;
      sa   <= 1'b0;
      sb   <= 1'b0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_div <= 1'b0;
      dz     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc <= {32'd0, is_div ? abs_a : abs_b};
            opb <= is_div ? abs_b : abs_a;
            sa  <= op_signed & a[31];
            sb  <= op_signed & b[31];
            cnt <= 5'd31;
`ifdef MULDIV_DIV_EN
            op_div <= is_div;
            dz     <= (b == '0);
`endif
          end else if (start && sel == SEL_MTHI) begin
            hi <= a;
          end else if (start && sel == SEL_MTLO) begin
            lo <= a;
          end
        end
        S_MUL: begin
          acc <= acc_mul;
          cnt <= cnt - 5'd1;
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          acc <= acc_div;
          cnt <= cnt - 5'd1;
        end
`endif
        S_FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
